sysid_check_master: RTL and testbench
=====================================

Name: sysid_check_master

Overview:
- Avalon-MM read master that runs at the initiator end of the system-ID slave interface.
- Reads word 0 (system ID) and word 1 (build timestamp) from the sysid slave, then compares both against expected values.
- Reports pass/fail/timeout status to board-level LEDs and the HDMI bring-up sequencer, which gates video start on id_ok && ts_ok.

Parameters:
- EXPECTED_ID, 0, expected value at sysid address 0.
- EXPECTED_TS, 1539181635, expected value at sysid address 1 (build timestamp).
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest-high cycles allowed per read; range 1..65535.
- AUTO_START, 1, if 1, launch one check automatically on the first clock after reset deasserts.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that (re)runs the check; ignored while busy=1.
- avm_address  out  1  word address: 0 = ID, 1 = timestamp.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall signal.
- avm_readdata  in  32  read data; fixed latency 0, valid in the cycle where avm_read=1 and avm_waitrequest=0.
- busy  out  1  high from launch until done is set.
- done  out  1  level; high after a check completes, held until the next launch.
- id_ok  out  1  captured ID == EXPECTED_ID; meaningful only when done=1.
- ts_ok  out  1  captured timestamp == EXPECTED_TS; meaningful only when done=1.
- timeout  out  1  the check aborted on a waitrequest timeout.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, timeout counter 0.
- Reset mid-operation: avm_read drops asynchronously; no partial results are kept.
- FSM states: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE -> RD_ID on start=1, or on the first cycle after reset deasserts when AUTO_START=1.
- DONE -> RD_ID on start=1. Launching clears done, id_ok, ts_ok, timeout, id_value and ts_value, and sets busy.
- RD_ID: avm_read=1, avm_address=0, both held stable while avm_waitrequest=1.
  - On the accept cycle (avm_waitrequest=0), capture avm_readdata into id_value and go to RD_TS.
- RD_TS: the same handshake with avm_address=1. Capture into ts_value, then go to CHECK.
- CHECK (1 cycle): avm_read=0. Register id_ok and ts_ok (full 32-bit equality), set done=1, clear busy, go to DONE.
- Timeout counter (16 bits):
  - Clears on entry to each read state and on every accept.
  - Increments each cycle avm_read=1 and avm_waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1 and done=1, leave id_ok=ts_ok=0, clear busy, go to DONE without capturing.
- Accept and timeout in the same cycle: accept wins.
- No back-to-back gap is needed between the two reads: if avm_waitrequest is low throughout, avm_read stays high for 2 consecutive cycles (address 0, then 1).
- Latency with zero wait states:
  - start high in cycle N -> read at address 0 in N+1, address 1 in N+2, CHECK in N+3.
  - done, id_ok and ts_ok are visible in N+4.
- start asserted while busy=1 is dropped (not queued).
- avm_read is never asserted outside RD_ID/RD_TS.

Optional Feature:
- Macro: SYSID_RECHECK_EN.
- Defined:
  - Adds parameter RECHECK_PERIOD (default 50000000) and output port mismatch_sticky (1 bit).
  - While in DONE, a 32-bit counter counts clocks; at RECHECK_PERIOD it relaunches the check exactly as start does. The counter resets on each launch.
  - mismatch_sticky sets on any completion with id_ok=0, ts_ok=0 or timeout=1. Only reset clears it.
- Undefined: no periodic relaunch, no mismatch_sticky port. Checks run only on AUTO_START and start.

Test Plan:
- Slave returns 0 / 1539181635 with no wait states; pulse start at cycle 10 -> avm_read high in cycles 11-12 with address 0 then 1; done=1, id_ok=1, ts_ok=1 at cycle 14.
- Slave holds waitrequest for 3 cycles on each read -> address and read stay stable while stalled; done=1, id_ok=ts_ok=1, timeout=0.
- Slave returns 0x12345678 at address 1 -> ts_value=0x12345678, ts_ok=0, id_ok=1, done=1.
- TIMEOUT_CYCLES=8 with waitrequest stuck high -> avm_read drops after 8 stalled cycles in RD_ID; timeout=1, done=1, id_ok=0; a later start with a healthy slave passes and clears timeout.
- Assert reset during RD_TS stall -> avm_read=0 immediately; all outputs 0; AUTO_START=1 relaunches after release; start pulsed while busy has no effect.
- SYSID_RECHECK_EN defined, RECHECK_PERIOD=100, slave ID changed to 5 between checks -> second check launches 100 cycles after the first done; id_ok=0; mismatch_sticky=1 and stays 1 after the ID is restored.

Source files
------------

// File: rtl/sysid_check_master.sv
// Avalon-MM read master: reads sysid word 0 (ID) and word 1 (timestamp), compares against expected values.
// Optional macro SYSID_RECHECK_EN adds periodic relaunch (RECHECK_PERIOD) and a mismatch_sticky output.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1539181635,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
`ifdef SYSID_RECHECK_EN
    ,
    parameter logic [31:0] RECHECK_PERIOD = 32'd50000000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_RECHECK_EN
    ,
    output logic        mismatch_sticky
`endif
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

    // Stall count that triggers the abort on the cycle it would reach TIMEOUT_CYCLES.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        auto_q, auto_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic        launch, recheck;
`ifdef SYSID_RECHECK_EN
    logic [31:0] rc_cnt_q, rc_cnt_d;
    logic        sticky_q, sticky_d;
`endif

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        auto_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        launch     = 1'b0;
        recheck    = 1'b0;
`ifdef SYSID_RECHECK_EN
        sticky_d   = sticky_q;
        rc_cnt_d   = (state_q == DONE) ? rc_cnt_q + 32'd1 : rc_cnt_q;
        recheck    = (state_q == DONE) && (rc_cnt_q == RECHECK_PERIOD - 32'd1);
`endif
        case (state_q)
            IDLE:    launch = start || auto_q;
            DONE:    launch = start || recheck;
            default: launch = 1'b0;
        endcase

        case (state_q)
            RD_ID, RD_TS: begin
                if (!avm_waitrequest) begin
                    tcnt_d = 16'd0;
                    if (state_q == RD_ID) begin
                        id_value_d = avm_readdata;
                        state_d    = RD_TS;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = CHECK;
                    end
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                    if (tcnt_q == TO_LAST) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
`ifdef SYSID_RECHECK_EN
                        sticky_d  = 1'b1;
`endif
                    end
                end
            end
            CHECK: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TS);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
`ifdef SYSID_RECHECK_EN
                if ((id_value_q != EXPECTED_ID) || (ts_value_q != EXPECTED_TS))
                    sticky_d = 1'b1;
`endif
            end
            default: ;
        endcase

        // A launch wipes every result of the previous check.
        if (launch) begin
            state_d    = RD_ID;
            tcnt_d     = 16'd0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            id_ok_d    = 1'b0;
            ts_ok_d    = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = 32'd0;
            ts_value_d = 32'd0;
`ifdef SYSID_RECHECK_EN
            rc_cnt_d   = 32'd0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tcnt_q     <= 16'd0;
            auto_q     <= AUTO_START;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
`ifdef SYSID_RECHECK_EN
            rc_cnt_q   <= 32'd0;
            sticky_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            auto_q     <= auto_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
`ifdef SYSID_RECHECK_EN
            rc_cnt_q   <= rc_cnt_d;
            sticky_q   <= sticky_d;
`endif
        end
    end

    // Decoded straight from state so an async reset drops the request immediately.
    assign avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
    assign avm_address = (state_q == RD_TS);
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;
`ifdef SYSID_RECHECK_EN
    assign mismatch_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: directed launches push expected completions; a monitor checks each rising done.
module tb_sysid_check_master;

    localparam int          TO     = 8;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1539181635;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
`ifdef SYSID_RECHECK_EN
    logic        mismatch_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    logic [31:0] slave_id = 32'd0;
    logic [31:0] slave_ts = EXP_TS;
    int          wait_n   = 0;
    bit          stuck    = 1'b0;
    int          stall_cnt = 0;
    logic        exp_addr = 1'b0;
    logic        done_prev = 1'b0;

    typedef struct {
        int          cyc;
        bit          id_ok;
        bit          ts_ok;
        bit          to;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    sysid_check_master #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TO),
        .AUTO_START     (1'b1)
`ifdef SYSID_RECHECK_EN
        ,
        .RECHECK_PERIOD (32'd100)
`endif
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .id_value        (id_value),
        .ts_value        (ts_value)
`ifdef SYSID_RECHECK_EN
        ,
        .mismatch_sticky (mismatch_sticky)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    assign avm_readdata = avm_address ? slave_ts : slave_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Slave model plus read-address model: address must be 0 until the first accept, then 1.
    always @(negedge clock) begin
        if (avm_read) begin
            chk("read_addr", avm_address, exp_addr);
            avm_waitrequest = stuck || (stall_cnt < wait_n);
            if (avm_waitrequest) stall_cnt++;
            else begin
                stall_cnt = 0;
                exp_addr  = ~exp_addr;
            end
        end else begin
            stall_cnt       = 0;
            exp_addr        = 1'b0;
            avm_waitrequest = stuck;
        end
    end

    // Completion monitor.
    always @(negedge clock) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("id_ok", id_ok, mon_e.id_ok);
                chk("ts_ok", ts_ok, mon_e.ts_ok);
                chk("timeout", timeout, mon_e.to);
                chk("id_value", id_value, mon_e.idv);
                chk("ts_value", ts_value, mon_e.tsv);
                chk("busy_at_done", busy, 1'b0);
            end
            last_done_cyc = cyc;
        end
        done_prev = done;
    end

    task automatic push_exp(input int n, input int lat, input bit eid, input bit ets,
                            input bit eto, input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        e.cyc = n + lat; e.id_ok = eid; e.ts_ok = ets; e.to = eto; e.idv = idv; e.tsv = tsv;
        sb.push_back(e);
    endtask

    task automatic launch(input bit push, input int lat, input bit eid, input bit ets,
                          input bit eto, input logic [31:0] idv, input logic [31:0] tsv);
        @(posedge clock); #1;
        start = 1'b1;
        if (push) push_exp(cyc, lat, eid, ets, eto, idv, tsv);
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_launch", busy, 1'b1);
        chk("done_cleared", done, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clock); #1;
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got %0d pending completions after %0d cycles, expected 0", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        int k;
        #1;
        chk("rst_read", avm_read, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_id_ok", id_ok, 1'b0);
        chk("rst_ts_ok", ts_ok, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_id_value", id_value, 32'd0);
        chk("rst_ts_value", ts_value, 32'd0);
`ifdef SYSID_RECHECK_EN
        chk("rst_sticky", mismatch_sticky, 1'b0);
`endif
        // Auto-start: release during cycle R behaves like start in cycle R.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        push_exp(cyc, 4, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        wait_done(20);

        // Zero wait states.
        launch(1'b1, 4, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        wait_done(20);

        // Three stall cycles on each read.
        wait_n = 3;
        launch(1'b1, 10, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        wait_done(30);

        // Wrong timestamp.
        wait_n   = 0;
        slave_ts = 32'h12345678;
        launch(1'b1, 4, 1'b1, 1'b0, 1'b0, 32'd0, 32'h12345678);
        wait_done(20);
        slave_ts = EXP_TS;

        // Waitrequest stuck high: abort after TO stalled cycles, nothing captured.
        stuck = 1'b1;
        launch(1'b1, 1 + TO, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        wait_done(30);
        stuck = 1'b0;
        launch(1'b1, 4, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        wait_done(20);

        // Reset during RD_TS stall.
        slave_id = 32'h0000A5A5;
        wait_n   = 5;
        launch(1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        k = 0;
        while (!(avm_read && avm_address) && k < 40) begin
            @(negedge clock); #1;
            k++;
        end
        chk("reached_rd_ts", avm_read && avm_address, 1'b1);
        chk("id_captured_before_reset", id_value, 32'h0000A5A5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_read", avm_read, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_id_value", id_value, 32'd0);
        chk("mid_rst_ts_value", ts_value, 32'd0);
        @(negedge clock);
        slave_id = 32'd0;
        wait_n   = 0;
        @(negedge clock);
        reset = 1'b0;
        push_exp(cyc, 4, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        // Start while busy must be dropped.
        @(posedge clock); #1;
        chk("busy_before_ignored_start", busy, 1'b1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(20);
        repeat (10) @(negedge clock);
        #1;
        chk("idle_after_ignored_start", busy, 1'b0);
        chk("done_held", done, 1'b1);
`ifdef SYSID_RECHECK_EN
        chk("sticky_clean", mismatch_sticky, 1'b0);
        // Periodic relaunch: RD_ID 100 cycles after done, i.e. "start" at done+99.
        slave_id = 32'd5;
        push_exp(last_done_cyc + 99, 4, 1'b0, 1'b1, 1'b0, 32'd5, EXP_TS);
        wait_done(150);
        chk("sticky_set", mismatch_sticky, 1'b1);
        slave_id = 32'd0;
        push_exp(last_done_cyc + 99, 4, 1'b1, 1'b1, 1'b0, 32'd0, EXP_TS);
        wait_done(150);
        chk("sticky_held", mismatch_sticky, 1'b1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, expected completion");
        $fatal(1);
    end

endmodule
